// File: rtl/sram_ecc_pkg.sv
// sram_ecc_pkg: shared types and SECDED(39,32) code tables
// for the ECC SRAM controller.
package sram_ecc_pkg;

  localparam int DATA_W = 32;
  localparam int CODE_W = 39;
  localparam int ADDR_W = 13;
  localparam int CHK_W  = CODE_W - DATA_W;

  typedef enum logic {
    IDLE,
    RMW
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corr;
    logic              err;
  } dec_result_t;

  // Hsiao columns: the first 32 weight-3 patterns of 7 bits.
  // Odd-weight columns make every double error an even,
  // non-zero syndrome.
  localparam logic [CHK_W-1:0] H_COL [DATA_W] = '{
    7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
    7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
    7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49,
    7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62
  };

  function automatic logic [CHK_W-1:0] secded_chk(
    input logic [DATA_W-1:0] d
  );
    logic [CHK_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (d[i]) c = c ^ H_COL[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/sram_secded_39_32.sv
// sram_secded_39_32: combinational Hsiao SECDED encoder
// and decoder; codeword layout is {chk[6:0], data[31:0]}.
module sram_secded_39_32
  import sram_ecc_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [CHK_W-1:0]  chk_i,
  output logic [CHK_W-1:0]  chk_o,
  output dec_result_t       dec_o
);

  logic [CHK_W-1:0]  syn;
  logic [DATA_W-1:0] fixed;
  logic              hit;

  assign chk_o = secded_chk(data_i);
  assign syn   = chk_i ^ chk_o;

  // Locate a single flipped data bit by matching its column.
  always_comb begin
    fixed = data_i;
    hit   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (syn == H_COL[i]) begin
        fixed[i] = ~data_i[i];
        hit      = 1'b1;
      end
    end
  end

  // Classify: clean, single (data or check bit), else fatal.
  // Uncorrectable words pass the raw data through.
  always_comb begin
    dec_o.data = data_i;
    dec_o.corr = 1'b0;
    dec_o.err  = 1'b0;
    unique case (1'b1)
      (syn == '0): begin
        dec_o.data = data_i;
      end
      (hit || $onehot(syn)): begin
        dec_o.data = fixed;
        dec_o.corr = 1'b1;
      end
      default: begin
        dec_o.err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sram_ecc_ctrl.sv
// sram_ecc_ctrl: 32-bit request port to 8192x39 SRAM macro
// with SECDED encode/decode and read-modify-write.
module sram_ecc_ctrl
  import sram_ecc_pkg::*;
#(
  parameter logic [2:0] MC_VAL     = 3'b000,
  parameter logic       MCEN_VAL   = 1'b0,
  parameter logic [1:0] WPULSE_VAL = 2'b00,
  parameter int         CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [3:0]        req_be_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_corr_o,
  output logic              rsp_err_o,
  output logic [CNT_W-1:0]  corr_cnt_o,
  output logic              mem_ren_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [CODE_W-1:0] mem_din_o,
  output logic [CODE_W-1:0] mem_wbeb_o,
  input  logic [CODE_W-1:0] mem_q_i,
  output logic [2:0]        mem_mc_o,
  output logic              mem_mcen_o,
  output logic [1:0]        mem_wpulse_o,
  output logic [4:0]        mem_tie_o
);

  state_e            state_q, state_d;
  logic              rdy_q, rdy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic              rsp_rd_q, rsp_rd_d;
  logic              rsp_corr_q, rsp_corr_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] enc_data;
  logic [CHK_W-1:0]  enc_chk;
  dec_result_t       rd_dec;
  dec_result_t       unused_enc_dec;
  logic [CHK_W-1:0]  unused_dec_chk;

  assign mem_mc_o     = MC_VAL;
  assign mem_mcen_o   = MCEN_VAL;
  assign mem_wpulse_o = WPULSE_VAL;
  assign mem_tie_o    = '0;

  assign enc_data = (state_q == RMW) ? merged : req_wdata_i;

  sram_secded_39_32 u_enc (
    .data_i (enc_data),
    .chk_i  ('0),
    .chk_o  (enc_chk),
    .dec_o  (unused_enc_dec)
  );

  sram_secded_39_32 u_dec (
    .data_i (mem_q_i[DATA_W-1:0]),
    .chk_i  (mem_q_i[CODE_W-1:DATA_W]),
    .chk_o  (unused_dec_chk),
    .dec_o  (rd_dec)
  );

  // Overlay the enabled bytes of the pending write on the
  // corrected old word.
  always_comb begin
    merged = rd_dec.data;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Next-state, macro drive and response scheduling.
  always_comb begin
    state_d     = state_q;
    rdy_d       = 1'b1;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_vld_d   = 1'b0;
    rsp_rd_d    = 1'b0;
    rsp_corr_d  = 1'b0;
    rsp_err_d   = 1'b0;
    req_ready_o = 1'b0;
    mem_ren_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_adr_o   = '0;
    mem_din_o   = '0;
    mem_wbeb_o  = '1;
    unique case (state_q)
      IDLE: begin
        req_ready_o = rdy_q;
        if (req_valid_i && rdy_q) begin
          rsp_vld_d = 1'b1;
          if (!req_we_i) begin
            mem_ren_o = 1'b1;
            mem_adr_o = req_addr_i;
            rsp_rd_d  = 1'b1;
          end else if (req_be_i == 4'hF) begin
            mem_wen_o  = 1'b1;
            mem_adr_o  = req_addr_i;
            mem_din_o  = {enc_chk, req_wdata_i};
            mem_wbeb_o = '0;
          end else if (req_be_i != 4'h0) begin
            mem_ren_o = 1'b1;
            mem_adr_o = req_addr_i;
            addr_d    = req_addr_i;
            wdata_d   = req_wdata_i;
            be_d      = req_be_i;
            rsp_vld_d = 1'b0;
            state_d   = RMW;
          end
        end
      end
      RMW: begin
        mem_adr_o  = addr_q;
        mem_din_o  = {enc_chk, merged};
        mem_wen_o  = ~rd_dec.err;
        mem_wbeb_o = rd_dec.err ? '1 : '0;
        rsp_vld_d  = 1'b1;
        rsp_corr_d = rd_dec.corr;
        rsp_err_d  = rd_dec.err;
        state_d    = IDLE;
      end
    endcase
  end

  // Read responses decode live macro data; writes use flops.
  always_comb begin
    rsp_valid_o = rsp_vld_q;
    rsp_rdata_o = '0;
    rsp_corr_o  = 1'b0;
    rsp_err_o   = 1'b0;
    if (rsp_vld_q) begin
      if (rsp_rd_q) begin
        rsp_rdata_o = rd_dec.data;
        rsp_corr_o  = rd_dec.corr;
        rsp_err_o   = rd_dec.err;
      end else begin
        rsp_corr_o  = rsp_corr_q;
        rsp_err_o   = rsp_err_q;
      end
    end
  end

  // Saturating count of corrected responses.
  always_comb begin
    cnt_d = cnt_q;
    if (rsp_valid_o && rsp_corr_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign corr_cnt_o = cnt_q;

  // State and pipeline registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_rd_q   <= 1'b0;
      rsp_corr_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_corr_q <= rsp_corr_d;
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: doc/sram_ecc_ctrl.md
Name: sram_ecc_ctrl

Overview:
- Initiator/controller that drives the 8192x39 byte-enable SRAM macro from a 32-bit word request port.
- Adds SECDED(39,32) protection: encodes on write, decodes and corrects on read.
- Performs read-modify-write for partial (byte-masked) writes.
- Sits between the bus adapter and the macro instance; macro tie-off pins are driven from parameters.

Parameters:
- MC_VAL, 3'b000, value driven on macro mc.
- MCEN_VAL, 1'b0, value driven on macro mcen.
- WPULSE_VAL, 2'b00, value driven on macro wpulse; wpulseen, clkbyp, fwen and wa are driven 0.
- CNT_W, 16, width of the saturating corrected-error counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_we_i  in  1  1=write, 0=read.
- req_addr_i  in  13  word address.
- req_wdata_i  in  32  write data.
- req_be_i  in  4  byte enables, write only.
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata_o  out  32  corrected read data; 0 for writes.
- rsp_corr_o  out  1  single-bit error was corrected.
- rsp_err_o  out  1  uncorrectable error.
- corr_cnt_o  out  CNT_W  saturating count of corrected reads.
- mem_ren_o  out  1  macro read enable.
- mem_wen_o  out  1  macro write enable.
- mem_adr_o  out  13  macro address.
- mem_din_o  out  39  encoded write word.
- mem_wbeb_o  out  39  active-low bit write enable.
- mem_q_i  in  39  macro read data, valid the cycle after mem_ren_o.
- mem_mc_o/mem_mcen_o/mem_wpulse_o/mem_tie_o  out  3/1/2/5  static tie-offs.

Behaviour:
- Reset values:
  - req_ready_o=0 while reset is asserted; 1 from the first cycle after release.
  - rsp_valid_o, rsp_rdata_o, rsp_corr_o, rsp_err_o, corr_cnt_o, mem_ren_o, mem_wen_o, mem_adr_o, mem_din_o = 0.
  - mem_wbeb_o = all ones.
- FSM states: IDLE, RMW.
- IDLE:
  - req_ready_o=1.
  - On accept, mem_* outputs are driven combinationally in the accept cycle.
  - Read: mem_ren_o=1.
  - Write with be==4'hF: mem_wen_o=1, mem_din_o=enc(wdata), mem_wbeb_o=0.
  - Write with be!=4'hF: mem_ren_o=1, latch addr/wdata/be, go to RMW.
  - Write with be==0: no macro access; ack next cycle.
- RMW (exactly 1 cycle):
  - req_ready_o=0.
  - Decode mem_q_i, merge enabled bytes of the latched wdata, then mem_wen_o=1, mem_din_o=enc(merged), mem_wbeb_o=0.
  - If decode is uncorrectable: mem_wen_o=0, so memory is unchanged.
  - Always return to IDLE.
- Responses:
  - rsp_valid_o is a one-cycle pulse.
  - Read and full write: asserted in the cycle after accept.
  - Partial write: asserted in the cycle after RMW, i.e. 2 cycles after accept.
  - For a read, rdata/corr/err are decoded combinationally from mem_q_i.
  - For a partial write, corr/err are registered from the RMW decode.
  - For a full write, corr=err=0.
  - On an uncorrectable read, rdata = mem_q_i[31:0] raw.
- Throughput:
  - Back-to-back reads and full writes: one per cycle.
  - Partial write: one bubble cycle.
  - A read accepted the cycle after RMW returns the merged data.
- corr_cnt_o:
  - Increments on every response with rsp_corr_o=1 (reads and RMW).
  - Saturates at all ones.
- Concurrency: a response pulse and a new accept may occur in the same cycle.
- Reset mid-RMW:
  - The write is abandoned; no macro write and no response.
  - All outputs return to reset values asynchronously.

Decomposition:
- Package sram_ecc_pkg contains:
  - Constants: DATA_W=32, CODE_W=39, ADDR_W=13.
  - State enum: IDLE, RMW.
  - Typedef: dec_result_t {data, corr, err}.
- Sub-module sram_secded_39_32: combinational Hsiao SECDED encoder plus decoder.
  - Instantiated once for write encode and once for read decode.

Test Plan:
- Reset, then full write addr 0x0005, data 0xDEADBEEF, be 4'hF; then read 0x0005 -> rsp one cycle after each accept; read rdata 0xDEADBEEF, corr=0, err=0.
- Partial write be=4'b0010 data 0x0000AA00 to a word holding 0x11223344 -> wen asserted 1 cycle after accept; rsp 2 cycles after accept; a following read returns 0x1122AA44; req_ready_o low exactly 1 cycle.
- Macro model flips q bit 7 on read of 0x11223344 -> rdata 0x11223344, corr=1, corr_cnt_o +1.
- Flip two bits during the RMW read -> no mem_wen_o, err=1; a later read of the stored word (no flips) returns the original value.
- Reads to 0x1FFF and 0x0000 issued back-to-back on consecutive cycles -> two consecutive rsp pulses with the correct data; no bubble.
- Deassert rst_ni during the RMW cycle -> mem_wen_o=0 immediately, mem_wbeb_o all ones, no rsp; memory word unchanged.
